// File: rtl/sipo_shift_reg_pkg.sv
// Shared constants for the serial-in, parallel-out shift register.
// Default width and the shift-direction encoding.
package sipo_shift_reg_pkg;

   localparam int SIPO_WIDTH_DEFAULT = 4;
   localparam int SHIFT_DIR_RIGHT    = 1;
   localparam int SHIFT_DIR_LEFT     = 0;

endpackage

// File: rtl/sipo_shift_reg.sv
// Serial-in, parallel-out shift register with asynchronous active-low clear.
// Shifts one bit per rising edge; direction fixed at elaboration.
module sipo_shift_reg
   import sipo_shift_reg_pkg::*;
#(
   parameter int WIDTH       = SIPO_WIDTH_DEFAULT,
   parameter int SHIFT_RIGHT = SHIFT_DIR_RIGHT
) (
   input  logic             Clock,
   input  logic             Clear,
   input  logic             Sin,
   output logic [WIDTH-1:0] Pout
);

   generate
      if (WIDTH < 2) begin : g_bad_width
         $error("sipo_shift_reg: WIDTH must be 2 or more");
      end
      if (SHIFT_RIGHT != SHIFT_DIR_RIGHT &&
          SHIFT_RIGHT != SHIFT_DIR_LEFT) begin : g_bad_dir
         $error("sipo_shift_reg: SHIFT_RIGHT must be 0 or 1");
      end
   endgenerate

   logic [WIDTH-1:0] sr;
   logic [WIDTH-1:0] sr_nxt;

   // Entry stage is the MSB for right shifts, the LSB for left shifts.
   generate
      if (SHIFT_RIGHT == SHIFT_DIR_RIGHT) begin : g_right
         assign sr_nxt = {Sin, sr[WIDTH-1:1]};
      end else begin : g_left
         assign sr_nxt = {sr[WIDTH-2:0], Sin};
      end
   endgenerate

   always_ff @(posedge Clock or negedge Clear) begin
      if (!Clear) begin
         sr <= '0;
      end else begin
         sr <= sr_nxt;
      end
   end

   assign Pout = sr;

endmodule

// File: tb/tb_sipo_shift_reg.sv
// Scoreboard bench for sipo_shift_reg: 4-bit right, 4-bit left, 8-bit right.
// Stimulus pushes expected words; a monitor pops and compares on each sample.
module tb_sipo_shift_reg;

   logic       Clock = 1'b0;
   logic       Clear = 1'b0;
   logic       Sin   = 1'b1;
   logic       sin8  = 1'b1;
   logic [3:0] pout_r4;
   logic [3:0] pout_l4;
   logic [7:0] pout_w8;

   always #5 Clock = ~Clock;

   sipo_shift_reg #(.WIDTH(4), .SHIFT_RIGHT(1)) u_r4 (
      .Clock(Clock), .Clear(Clear), .Sin(Sin), .Pout(pout_r4)
   );

   sipo_shift_reg #(.WIDTH(4), .SHIFT_RIGHT(0)) u_l4 (
      .Clock(Clock), .Clear(Clear), .Sin(Sin), .Pout(pout_l4)
   );

   sipo_shift_reg #(.WIDTH(8), .SHIFT_RIGHT(1)) u_w8 (
      .Clock(Clock), .Clear(Clear), .Sin(sin8), .Pout(pout_w8)
   );

   typedef struct {
      int         dut;
      int         tag;
      logic [7:0] exp;
   } sb_t;

   sb_t  sbq[$];
   event sample_ev;
   int   n_checks = 0;
   int   n_pass   = 0;

   // Hand-computed streaming table, steps 1..12.
   logic       sin4_tab [12] = '{1,1,0,1, 0,0,0,0, 1,1,0,1};
   logic       sin8_tab [12] = '{1,0,1,0, 1,0,1,0, 1,0,1,0};
   logic [3:0] r4_tab   [12] = '{
      4'b1000, 4'b1100, 4'b0110, 4'b1011,
      4'b0101, 4'b0010, 4'b0001, 4'b0000,
      4'b1000, 4'b1100, 4'b0110, 4'b1011};
   logic [3:0] l4_tab   [12] = '{
      4'b0001, 4'b0011, 4'b0110, 4'b1101,
      4'b1010, 4'b0100, 4'b1000, 4'b0000,
      4'b0001, 4'b0011, 4'b0110, 4'b1101};
   logic [7:0] w8_tab   [12] = '{
      8'b10000000, 8'b01000000, 8'b10100000, 8'b01010000,
      8'b10101000, 8'b01010100, 8'b10101010, 8'b01010101,
      8'b10101010, 8'b01010101, 8'b10101010, 8'b01010101};

   task automatic push(input int dut, input int tag, input logic [7:0] exp);
      sb_t e;
      e.dut = dut;
      e.tag = tag;
      e.exp = exp;
      sbq.push_back(e);
   endtask

   task automatic push_all(input int tag, input logic [3:0] r4,
                           input logic [3:0] l4, input logic [7:0] w8);
      push(0, tag, {4'b0, r4});
      push(1, tag, {4'b0, l4});
      push(2, tag, w8);
      -> sample_ev;
   endtask

   // Drive between edges, then sample 1 unit after the next rising edge.
   task automatic step(input logic s, input logic s8);
      Sin  = s;
      sin8 = s8;
      @(posedge Clock);
      #1;
   endtask

   // Half-cycle clear pulse ending before the next rising edge.
   task automatic pulse_clear(input int tag);
      #4;
      Clear = 1'b0;
      #1;
      push_all(tag, 4'b0000, 4'b0000, 8'h00);
      #2;
      Clear = 1'b1;
   endtask

   initial begin : monitor
      sb_t        e;
      logic [7:0] act;
      string      nm;
      forever begin
         @(sample_ev);
         while (sbq.size() > 0) begin
            e = sbq.pop_front();
            case (e.dut)
               0:       begin act = {4'b0, pout_r4}; nm = "r4"; end
               1:       begin act = {4'b0, pout_l4}; nm = "l4"; end
               default: begin act = pout_w8;         nm = "w8"; end
            endcase
            n_checks++;
            if (act !== e.exp) begin
               $display("FAIL %s tag%0d: got %b want %b",
                        nm, e.tag, act, e.exp);
            end else begin
               n_pass++;
            end
         end
      end
   end

   initial begin : watchdog
      #20000;
      $display("FAIL watchdog: time limit reached, got hang want finish");
      $fatal(1, "timeout");
   end

   initial begin : stim
      // Clear held low from time 0, Sin=1, across three edges.
      #1;
      push_all(100, 4'b0000, 4'b0000, 8'h00);
      repeat (3) begin
         @(posedge Clock);
         #1;
         push_all(101, 4'b0000, 4'b0000, 8'h00);
      end
      #3;
      Clear = 1'b1;

      for (int i = 0; i < 12; i++) begin
         step(sin4_tab[i], sin8_tab[i]);
         push_all(i + 1, r4_tab[i], l4_tab[i], w8_tab[i]);
      end

      // r4 holds 1011 here; clear mid-cycle then resume from zero.
      Sin  = 1'b1;
      sin8 = 1'b1;
      pulse_clear(200);
      @(posedge Clock);
      #1;
      push_all(13, 4'b1000, 4'b0001, 8'b10000000);

      step(1'b1, 1'b0);
      push_all(14, 4'b1100, 4'b0011, 8'b01000000);

      pulse_clear(201);
      step(1'b1, 1'b1);
      push_all(15, 4'b1000, 4'b0001, 8'b10000000);

      #2;
      if (sbq.size() != 0) begin
         $display("FAIL drain: got %0d pending want 0", sbq.size());
         n_checks += sbq.size();
      end
      $display("%0d/%0d checks passed", n_pass, n_checks);
      $finish;
   end

endmodule
